loas_candidate_scanner: RTL
===========================

# loas_candidate_scanner

Producer side of the LoAS candidate stream. Takes one neuron job: a neuron ID, a per-column nonzero-weight mask, and per-column T-bit presynaptic spike trains. It emits one (neuron, col, score) candidate per cycle, in ascending column order, for every column where the weight is nonzero and the spike train is nonzero. It sits directly upstream of the candidate FIFO and drives that FIFO's `in_valid`/`in_ready`/`in_neuron`/`in_col`/`in_score` ports.

## Interface
- `NUM_COLS`, 16, number of columns per job
- `COL_ID_W`, `$clog2(NUM_COLS)`, column index width
- `NEURON_ID_W`, 4, neuron ID width
- `T`, 15, timesteps per spike train
- `SCORE_W`, `$clog2(T+1)`, score width; must hold T
- `CNT_W`, 16, statistics counter width

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `job_valid`  in  1  job offered
- `job_ready`  out  1  scanner can accept a job
- `job_neuron`  in  NEURON_ID_W  neuron ID of the job
- `job_wmask`  in  NUM_COLS  bit c = weight of column c is nonzero
- `job_spikes`  in  NUM_COLS*T  train of column c is at bits [c*T +: T]
- `out_valid`  out  1  candidate valid
- `out_ready`  in  1  downstream (FIFO) accepts
- `out_neuron`  out  NEURON_ID_W  candidate neuron
- `out_col`  out  COL_ID_W  candidate column
- `out_score`  out  SCORE_W  popcount of that column's spike train
- `out_last`  out  1  final candidate of the current job
- `job_done`  out  1  one-cycle pulse when a job completes
- `stat_cand_cnt`  out  CNT_W  total candidates handshaken, saturating

## Operation
- States: IDLE, SCAN.
- Registers: `st`, `neuron_q`, `pending[NUM_COLS]`, `spikes_q`, `job_done`, `stat_cand_cnt`.
- `job_ready = (st == IDLE)`.
- Job accept: the handshake is `job_valid & job_ready`. On accept:
  - `pending <= job_wmask & nz`, where `nz[c] = |job_spikes[c*T +: T]`.
  - Latch `neuron_q` and `spikes_q`.
  - If the `pending` value being loaded is nonzero, go to SCAN.
  - If it is zero, stay in IDLE and pulse `job_done` for one cycle. No candidate is emitted.
- Outputs in SCAN are derived from registers only; there is no combinational path from `out_ready` to any output.
  - `out_valid = (st == SCAN)`.
  - `out_col` = index of the lowest set bit of `pending`.
  - `out_score` = popcount of `spikes_q[out_col*T +: T]`; always in 1..T.
  - `out_neuron = neuron_q`.
  - `out_last = 1` when `pending` has exactly one bit set.
- On `out_valid & out_ready`:
  - Clear `pending[out_col]`.
  - Increment `stat_cand_cnt`, saturating at all-ones.
  - If `out_last`, go to IDLE and set `job_done = 1` for the next cycle.
- While `out_valid = 1 & out_ready = 0`: all `out_*` are held stable. No candidate is dropped or reordered.
- Outside IDLE/SCAN, `out_neuron`/`out_col`/`out_score` are don't-care. The bench must check them only when `out_valid = 1`.
- `job_done` is deasserted in every cycle that is not the completion cycle.

## Timing
- Reset values: `st` = IDLE, `job_ready = 1`, `out_valid = 0`, `out_last = 0`, `job_done = 0`, `stat_cand_cnt = 0`, `pending = 0`. Reset applies immediately when `rst_n` falls.
- Reset mid-job: the job is abandoned. There is no `job_done` pulse, and after reset the outputs are as listed above.
- Latency: job accepted at edge N gives `out_valid = 1` with the first candidate from edge N to edge N+1.
- Throughput: one candidate per cycle while `out_ready = 1`. A job with k candidates under continuous ready occupies k cycles in SCAN.
- Completion: the last handshake at edge E gives `job_done = 1` and `job_ready = 1` in the cycle after E.
  - A new job may be accepted at the edge ending that cycle, so there is one idle bubble between jobs.
- Empty job accepted at edge N: `job_done = 1` in cycle N+1, and `job_ready` stays 1 throughout. Back-to-back empty jobs are accepted every cycle, with one `job_done` pulse each.
- `job_*` inputs are sampled only at accept and may change freely afterwards.
- Boundaries:
  - Column NUM_COLS-1 is emitted normally.
  - A column with a nonzero weight and an all-zero train is skipped.
  - A column with an all-ones train has score T.
  - `stat_cand_cnt` holds at 2^CNT_W-1 once it reaches it.

## Test plan
- Basic job: `neuron = 3`, `wmask = 0x0015`, col0 train popcount 2, col2 popcount 5, col4 popcount 15, `out_ready = 1`.
  - Expect candidates (3,0,2), (3,2,5), (3,4,15) on consecutive cycles, `out_last` on the third, `job_done` on the following cycle, `stat_cand_cnt = 3`.
- Filtering: `wmask = 0xFFFF`, only col 7 and col 15 have nonzero trains (popcounts 1 and 15).
  - Expect exactly (n,7,1) then (n,15,15).
- Backpressure: same job as the basic case, `out_ready` toggling 1,0,0,1,1.
  - Expect `out_*` stable during stalls, identical sequence to the basic case, no duplicates or losses.
- Empty job: `wmask = 0x00F0`, trains zero on cols 4-7.
  - Expect no `out_valid`, `job_done` in cycle N+1, `job_ready` held 1.
  - Then two back-to-back empty jobs: two `job_done` pulses.
- Back-to-back non-empty jobs: second `job_valid` held high from the start.
  - Expect the second job accepted in the `job_done` cycle and its first candidate one cycle later.
- Reset: deassert `rst_n` after the first of three candidates.
  - Expect `out_valid = 0`, `job_done = 0`, `stat_cand_cnt = 0`, `job_ready = 1` immediately.
  - A new job then runs cleanly from its first column.

Source files
------------

// File: rtl/loas_candidate_scanner_if.sv
// Candidate-scanner bus: job intake plus candidate stream toward the FIFO.
// Handshake rule (both channels): a transfer happens on a rising clk edge
// when valid and ready are both high; the sender holds its payload stable
// while valid is high and ready is low; valid never waits on ready.
interface loas_candidate_scanner_if #(
  parameter int NUM_COLS    = 16,
  parameter int NEURON_ID_W = 4,
  parameter int T           = 15,
  parameter int CNT_W       = 16
);
  localparam int COL_ID_W = $clog2(NUM_COLS);
  localparam int SCORE_W  = $clog2(T + 1);

  logic                      job_valid;
  logic                      job_ready;
  logic [NEURON_ID_W-1:0]    job_neuron;
  logic [NUM_COLS-1:0]       job_wmask;
  logic [NUM_COLS*T-1:0]     job_spikes;
  logic                      out_valid;
  logic                      out_ready;
  logic [NEURON_ID_W-1:0]    out_neuron;
  logic [COL_ID_W-1:0]       out_col;
  logic [SCORE_W-1:0]        out_score;
  logic                      out_last;
  logic                      job_done;
  logic [CNT_W-1:0]          stat_cand_cnt;

  // Scanner side
  modport master (
    input  job_valid, job_neuron, job_wmask, job_spikes, out_ready,
    output job_ready, out_valid, out_neuron, out_col, out_score, out_last,
           job_done, stat_cand_cnt
  );

  // Environment side: job source and candidate sink
  modport slave (
    output job_valid, job_neuron, job_wmask, job_spikes, out_ready,
    input  job_ready, out_valid, out_neuron, out_col, out_score, out_last,
           job_done, stat_cand_cnt
  );
endinterface

// File: rtl/loas_candidate_scanner.sv
// Takes one neuron job and emits one (neuron, col, score) candidate per
// cycle, lowest column first, for each column with a nonzero weight and a
// nonzero spike train. All candidate outputs come from registers.
module loas_candidate_scanner #(
  parameter int NUM_COLS    = 16,
  parameter int NEURON_ID_W = 4,
  parameter int T           = 15,
  parameter int CNT_W       = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  loas_candidate_scanner_if.master bus,
  output logic [0:0]              dbg_state
);
  localparam int COL_ID_W = $clog2(NUM_COLS);
  localparam int SCORE_W  = $clog2(T + 1);

  typedef enum logic [0:0] {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t                 st, st_d;
  logic [NEURON_ID_W-1:0] neuron_q;
  logic [NUM_COLS-1:0]    pending, pending_d;
  logic [NUM_COLS-1:0]    nz, load_mask;
  logic [NUM_COLS*T-1:0]  spikes_q;
  logic                   done_q, done_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [COL_ID_W-1:0]    col_sel;
  logic [SCORE_W-1:0]     score_sel;
  logic                   last_sel;
  logic                   accept, fire;

  // Which incoming columns carry at least one spike
  always_comb begin
    nz = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      nz[c] = |bus.job_spikes[c*T +: T];
    end
  end

  assign load_mask = bus.job_wmask & nz;

  // Lowest pending column and the popcount of its latched train
  always_comb begin
    col_sel   = '0;
    score_sel = '0;
    for (int c = NUM_COLS - 1; c >= 0; c--) begin
      if (pending[c]) begin
        col_sel   = COL_ID_W'(c);
        score_sel = SCORE_W'($countones(spikes_q[c*T +: T]));
      end
    end
  end

  assign last_sel = (st == SCAN) && $onehot(pending);
  assign accept   = bus.job_valid & bus.job_ready;
  assign fire     = bus.out_valid & bus.out_ready;

  assign bus.job_ready     = (st == IDLE);
  assign bus.out_valid     = (st == SCAN);
  assign bus.out_neuron    = neuron_q;
  assign bus.out_col       = col_sel;
  assign bus.out_score     = score_sel;
  assign bus.out_last      = last_sel;
  assign bus.job_done      = done_q;
  assign bus.stat_cand_cnt = cnt_q;
  assign dbg_state         = st;

  // Next state, pending mask and completion pulse
  always_comb begin
    st_d      = st;
    pending_d = pending;
    done_d    = 1'b0;
    case (st)
      IDLE: begin
        if (accept) begin
          pending_d = load_mask;
          if (load_mask != '0) st_d = SCAN;
          else                 done_d = 1'b1;
        end
      end
      SCAN: begin
        if (fire) begin
          pending_d[col_sel] = 1'b0;
          if (last_sel) begin
            st_d   = IDLE;
            done_d = 1'b1;
          end
        end
      end
      default: st_d = IDLE;
    endcase
  end

  // State, job payload latch and saturating candidate counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= IDLE;
      pending  <= '0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      neuron_q <= '0;
      spikes_q <= '0;
    end else begin
      st      <= st_d;
      pending <= pending_d;
      done_q  <= done_d;
      if (fire && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
      if (accept) begin
        neuron_q <= bus.job_neuron;
        spikes_q <= bus.job_spikes;
      end
    end
  end
endmodule
